// File: rtl/mult_hilo_pkg.sv
// rtl/mult_hilo_pkg.sv - shared encodings, widths and helpers for the HI/LO multiply stage
package mult_hilo_pkg;

  localparam int OPW = 16;
  localparam int PW  = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MFHI  = 3'd3,
    OP_MFLO  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  // 0x8000 maps to itself, which is the exact unsigned magnitude.
  function automatic logic [OPW-1:0] mag(input logic [OPW-1:0] x);
    return x[OPW-1] ? (~x + {{(OPW-1){1'b0}}, 1'b1}) : x;
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// rtl/hilo_regs.sv - HI/LO register pair with independent write enables and a read mux
module hilo_regs
  import mult_hilo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          hi_we,
  input  logic [PW-1:0] hi_wd,
  input  logic          lo_we,
  input  logic [PW-1:0] lo_wd,
  input  logic          rd_hi,
  input  logic          rd_lo,
  output logic [PW-1:0] rdata
);

  logic [PW-1:0] hi;
  logic [PW-1:0] lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_wd;
      if (lo_we) lo <= lo_wd;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_hi)      rdata = hi;
    else if (rd_lo) rdata = lo;
  end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// rtl/mult_hilo_ctrl.sv - issue/writeback control for the 16x16 multiplier and HI/LO pair
module mult_hilo_ctrl
  import mult_hilo_pkg::*;
(
  input  logic           Clk,
  input  logic           Rst,
  input  logic [2:0]     Op,
  input  logic [31:0]    Rs,
  input  logic [31:0]    Rt,
  output logic           Stall,
  output logic [PW-1:0]  Rdata,
  output logic           Mul_St,
  output logic [OPW-1:0] Mul_A,
  output logic [OPW-1:0] Mul_B,
  input  logic           Mul_Idle,
  input  logic           Mul_Done,
  input  logic [PW-1:0]  Mul_Produto
);

  state_e        state, state_n;
  logic          neg, sgn;
  logic [PW-1:0] p;
  logic [PW-1:0] lo_res, hi_res;
  logic          idle, in_write;
  logic          hi_we, lo_we;
  logic [PW-1:0] hi_wd, lo_wd;
  logic          unused_rt_hi;

  assign unused_rt_hi = ^Rt[31:16];

  assign idle     = (state == S_IDLE);
  assign in_write = (state == S_WRITE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
      Mul_A <= '0;
      Mul_B <= '0;
      neg   <= 1'b0;
      sgn   <= 1'b0;
      p     <= '0;
    end else begin
      state <= state_n;
      // Operands are loaded only on acceptance, so they hold through S_WRITE.
      if (idle && Op == OP_MULT) begin
        Mul_A <= mag(Rs[OPW-1:0]);
        Mul_B <= mag(Rt[OPW-1:0]);
        neg   <= Rs[OPW-1] ^ Rt[OPW-1];
        sgn   <= 1'b1;
      end else if (idle && Op == OP_MULTU) begin
        Mul_A <= Rs[OPW-1:0];
        Mul_B <= Rt[OPW-1:0];
        neg   <= 1'b0;
        sgn   <= 1'b0;
      end
      if (state == S_WAIT && Mul_Done) p <= Mul_Produto;
    end
  end

  always_comb begin
    state_n = state;
    Mul_St  = 1'b0;
    case (state)
      S_IDLE:  if (Op == OP_MULT || Op == OP_MULTU) state_n = S_START;
      S_START: begin
        Mul_St = 1'b1;
        if (!Mul_Idle) state_n = S_WAIT;
      end
      S_WAIT:  if (Mul_Done) state_n = S_WRITE;
      S_WRITE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign lo_res = neg ? (~p + {{(PW-1){1'b0}}, 1'b1}) : p;
  assign hi_res = {PW{sgn && neg && (p != '0)}};

  assign hi_we = in_write || (idle && Op == OP_MTHI);
  assign lo_we = in_write || (idle && Op == OP_MTLO);
  assign hi_wd = in_write ? hi_res : Rs;
  assign lo_wd = in_write ? lo_res : Rs;

  assign Stall = !idle && (Op != OP_NOP);

  hilo_regs u_regs (
    .clk   (Clk),
    .rst   (Rst),
    .hi_we (hi_we),
    .hi_wd (hi_wd),
    .lo_we (lo_we),
    .lo_wd (lo_wd),
    .rd_hi (Op == OP_MFHI),
    .rd_lo (Op == OP_MFLO),
    .rdata (Rdata)
  );

endmodule

// File: doc/mult_hilo_ctrl.md
# mult_hilo_ctrl

Issue and writeback stage in front of the 16x16 shift-add multiplier. Accepts MULT/MULTU/MFHI/MFLO/MTHI/MTLO from the execute stage, conditions operands (signed magnitude for MULT), and starts the multiplier with a St/Idle handshake. On Done it captures the 32-bit product, applies the sign, and writes the HI/LO pair. It stalls the pipeline while a multiply is in flight.

## Interface
- No parameters. Operand width is fixed at 16 and product width at 32.
- Clk  in  1  single clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Op  in  3  operation code. Encodings are in the package: NOP=0, MULT=1, MULTU=2, MFHI=3, MFLO=4, MTHI=5, MTLO=6.
- Rs  in  32  source A. Bits [15:0] are the multiply operand. The full 32 bits are used for MTHI/MTLO.
- Rt  in  32  source B. Bits [15:0] are the multiply operand.
- Stall  out  1  pipeline must hold Op/Rs/Rt this cycle.
- Rdata  out  32  HI or LO value for MFHI/MFLO.
- Mul_St  out  1  start request to the multiplier.
- Mul_A  out  16  multiplicand, registered.
- Mul_B  out  16  multiplier operand, registered.
- Mul_Idle  in  1  multiplier idle flag.
- Mul_Done  in  1  multiplier done flag.
- Mul_Produto  in  32  unsigned product.

## Operation
States:
- S_IDLE: not busy; accepts any Op.
- S_START: Mul_St=1, held.
- S_WAIT: waiting for Mul_Done.
- S_WRITE: result is written to HI/LO.

Behaviour in S_IDLE:
- MULTU: Mul_A=Rs[15:0], Mul_B=Rt[15:0], neg=0, go to S_START.
- MULT: Mul_A=|Rs[15:0]|, Mul_B=|Rt[15:0]| (two's-complement magnitude), neg=Rs[15]^Rt[15], sgn=1, go to S_START.
  - Magnitude of 0x8000 is 0x8000. The unsigned 16-bit value is exact.
- MTHI/MTLO: write the full Rs into HI/LO at this edge. Stay in S_IDLE.
- MFHI/MFLO: Rdata=HI/LO combinationally, Stall=0.
- NOP: nothing.

S_START:
- Mul_St=1 every cycle while Mul_Idle=1.
- On the first sampled Mul_Idle=0, go to S_WAIT. Mul_St drops that same edge.

S_WAIT:
- On Mul_Done=1, register P=Mul_Produto and go to S_WRITE.

S_WRITE:
- LO = neg ? -P : P (32-bit two's complement).
- HI = {32{neg && P!=0}} for MULT, and 0 for MULTU.
- Go to S_IDLE.

Stall rules:
- Stall=1 whenever state!=S_IDLE and Op!=NOP. Any op arriving while busy (including a second MULT) is held, not dropped.
- In S_IDLE, Stall=0 for all ops. A MULT is accepted without stall; the next op stalls.

Other:
- Rdata=0 when Op is not MFHI/MFLO.
- Arithmetic: |x| ≤ 2^15, so the product is ≤ 2^30 and negation never overflows 32 bits.

## Timing
- Reset values:
  - state=S_IDLE, HI=0, LO=0.
  - Mul_St=0, Mul_A=0, Mul_B=0.
  - Stall=0, Rdata=0.
- Reset mid-operation (any state): same values at the next edge. In-flight product is discarded. The multiplier shares Rst.
- MULT accepted at edge t:
  - Mul_St=1 from t.
  - S_WAIT entered at the edge where Mul_Idle=0 is first sampled.
  - Mul_Done sampled high at edge d, S_WRITE during cycle d→d+1.
  - HI/LO visible and state=S_IDLE after edge d+1.
  - An MFLO held under Stall completes in cycle d+1→d+2.
- Mul_Done high while not in S_WAIT: ignored.
- Mul_A/Mul_B stay stable from acceptance until S_WRITE exits.
- MTHI/MTLO write at the edge they are seen in S_IDLE. An MFHI in the next cycle returns the new value.

## Structure
- Package mult_hilo_pkg holds:
  - Op encodings (3-bit).
  - State enum: S_IDLE, S_START, S_WAIT, S_WRITE.
  - Constants OPW=16 and PW=32.
- One natural sub-module: hilo_regs. It is the HI/LO register pair with synchronous Rst, separate write enables, and a read mux.
- The FSM, operand conditioning and sign fix-up live in the top.

## Test plan
- MULTU Rs=0x0000FFFF, Rt=0x0000FFFF → Mul_A=Mul_B=0xFFFF; after Done, LO=0xFFFE0001, HI=0; MFLO returns 0xFFFE0001.
- MULT Rs=0xFFFFFFFD (-3), Rt=5 → Mul_A=3, Mul_B=5; LO=0xFFFFFFF1, HI=0xFFFFFFFF.
- MULT Rs=0x8000, Rt=0x8000 → Mul_A=Mul_B=0x8000; LO=0x40000000, HI=0.
  - Also MULT -7×0: LO=0, HI=0.
- MULT followed by MFLO on the next cycle:
  - Stall=1 through S_START/S_WAIT/S_WRITE.
  - Mul_St held until Mul_Idle falls.
  - MFLO returns the product in the cycle after S_WRITE.
- MTHI Rs=0x12345678, then MFHI → Rdata=0x12345678 with Stall=0.
- Rst asserted in S_WAIT → next cycle state=S_IDLE, HI=LO=0, Stall=0, Mul_St=0; a later Mul_Done pulse has no effect.
